rsa_cmd_ctrl: RTL and testbench

Command sequencer between the ARM command/data handshake interface and the RSA datapath. It holds the operand registers, the Montgomery multiplier and the exponentiation engine.
- Decodes one 32-bit command at a time.
- Generates operand-register load strobes and core start pulses.
- Waits for core completion, runs the result read-out handshake, then signals done until the ARM acknowledges.
- Carries no 1024-bit data. It only controls the datapath registers.

---
 rtl/rsa_cmd_ctrl.sv | 154 +++++++++++++++
 tb/tb_rsa_cmd_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_cmd_ctrl.sv
// rsa_cmd_ctrl: command sequencer between the ARM handshake interface and the
// RSA datapath. It decodes one command at a time, fires operand load strobes
// and core start pulses, waits for core completion, runs the result read-out
// handshake and holds done until the ARM acknowledges it.
module rsa_cmd_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      arm_to_fpga_cmd,
  input  logic             arm_to_fpga_cmd_valid,
  output logic             fpga_to_arm_done,
  input  logic             fpga_to_arm_done_read,
  input  logic             arm_to_fpga_data_valid,
  output logic             arm_to_fpga_data_ready,
  output logic             fpga_to_arm_data_valid,
  input  logic             fpga_to_arm_data_ready,
  output logic             ld_mod,
  output logic             ld_rsq,
  output logic             ld_exp,
  output logic             mont_start,
  output logic             exp_start,
  input  logic             mont_done,
  input  logic             exp_done,
  output logic             res_sel,
  output logic             cmd_err,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [3:0]       leds
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RX    = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_TX    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] CMD_EXP   = 3'd0;
  localparam logic [2:0] CMD_MONT  = 3'd1;
  localparam logic [2:0] CMD_RMOD  = 3'd2;
  localparam logic [2:0] CMD_RRSQ  = 3'd3;
  localparam logic [2:0] CMD_REXP  = 3'd4;
  localparam logic [2:0] CMD_WRITE = 3'd5;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cmd_q;
  logic       res_valid;
  logic [2:0] state_bits;
  logic       cmd_illegal;
  logic       core_done;

  // Reserved upper bits or an unassigned opcode make the command illegal.
  assign cmd_illegal = (|arm_to_fpga_cmd[31:3]) || (arm_to_fpga_cmd[2:0] > CMD_WRITE);

  // Only the core that was started may end BUSY; the other core's done is ignored.
  assign core_done = (cmd_q == CMD_EXP) ? exp_done : mont_done;

  assign state_bits = state;
  assign leds       = {cmd_err, res_valid, state_bits[1:0]};

  // Next-state decode and Moore/Mealy handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nxt              = state;
    fpga_to_arm_done       = 1'b0;
    arm_to_fpga_data_ready = 1'b0;
    fpga_to_arm_data_valid = 1'b0;
    ld_mod                 = 1'b0;
    ld_rsq                 = 1'b0;
    ld_exp                 = 1'b0;
    mont_start             = 1'b0;
    exp_start              = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          if (cmd_illegal) begin
            state_nxt = S_DONE;
          end else begin
            case (arm_to_fpga_cmd[2:0])
              CMD_EXP, CMD_MONT:           state_nxt = S_START;
              CMD_RMOD, CMD_RRSQ, CMD_REXP: state_nxt = S_RX;
              default:                     state_nxt = res_valid ? S_TX : S_DONE;
            endcase
          end
        end
      end
      S_RX: begin
        arm_to_fpga_data_ready = 1'b1;
        if (arm_to_fpga_data_valid) begin
          ld_mod    = (cmd_q == CMD_RMOD);
          ld_rsq    = (cmd_q == CMD_RRSQ);
          ld_exp    = (cmd_q == CMD_REXP);
          state_nxt = S_DONE;
        end
      end
      S_START: begin
        mont_start = (cmd_q == CMD_MONT);
        exp_start  = (cmd_q == CMD_EXP);
        state_nxt  = S_BUSY;
      end
      S_BUSY: begin
        if (core_done) state_nxt = S_DONE;
      end
      S_TX: begin
        fpga_to_arm_data_valid = 1'b1;
        if (fpga_to_arm_data_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        fpga_to_arm_done = 1'b1;
        if (fpga_to_arm_done_read) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus command latch, error flag, result flags and busy counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= S_IDLE;
      cmd_q       <= 3'd0;
      cmd_err     <= 1'b0;
      res_valid   <= 1'b0;
      res_sel     <= 1'b0;
      busy_cycles <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (arm_to_fpga_cmd_valid) begin
            cmd_q   <= arm_to_fpga_cmd[2:0];
            cmd_err <= cmd_illegal || ((arm_to_fpga_cmd[2:0] == CMD_WRITE) && !res_valid);
          end
        end
        S_START: begin
          res_sel     <= (cmd_q == CMD_EXP);
          res_valid   <= 1'b0;
          busy_cycles <= '0;
        end
        S_BUSY: begin
          if (busy_cycles != '1) busy_cycles <= busy_cycles + CNT_W'(1);
          if (core_done) res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// tb_rsa_cmd_ctrl: scoreboard bench for rsa_cmd_ctrl. Each command pushes its
// expected outcome (error flag, result select, busy count, strobe counts) and
// the entry is popped and compared when the DUT raises done.
module tb_rsa_cmd_ctrl;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      arm_to_fpga_cmd;
  logic             arm_to_fpga_cmd_valid;
  logic             fpga_to_arm_done;
  logic             fpga_to_arm_done_read;
  logic             arm_to_fpga_data_valid;
  logic             arm_to_fpga_data_ready;
  logic             fpga_to_arm_data_valid;
  logic             fpga_to_arm_data_ready;
  logic             ld_mod, ld_rsq, ld_exp;
  logic             mont_start, exp_start;
  logic             mont_done, exp_done;
  logic             res_sel;
  logic             cmd_err;
  logic [CNT_W-1:0] busy_cycles;
  logic [3:0]       leds;

  rsa_cmd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .arm_to_fpga_cmd        (arm_to_fpga_cmd),
    .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
    .fpga_to_arm_done       (fpga_to_arm_done),
    .fpga_to_arm_done_read  (fpga_to_arm_done_read),
    .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
    .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
    .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
    .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
    .ld_mod                 (ld_mod),
    .ld_rsq                 (ld_rsq),
    .ld_exp                 (ld_exp),
    .mont_start             (mont_start),
    .exp_start              (exp_start),
    .mont_done              (mont_done),
    .exp_done               (exp_done),
    .res_sel                (res_sel),
    .cmd_err                (cmd_err),
    .busy_cycles            (busy_cycles),
    .leds                   (leds)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Strobe monitor: index 0 ld_mod, 1 ld_rsq, 2 ld_exp, 3 mont_start, 4 exp_start.
  int cnt [5] = '{default: 0};
  int ld_unready = 0;
  always begin
    @(negedge clk);
    #2;
    if (ld_mod)     cnt[0]++;
    if (ld_rsq)     cnt[1]++;
    if (ld_exp)     cnt[2]++;
    if (mont_start) cnt[3]++;
    if (exp_start)  cnt[4]++;
    if ((ld_mod || ld_rsq || ld_exp) && !arm_to_fpga_data_ready) ld_unready++;
  end

  typedef struct {
    string            tag;
    bit               err;
    bit               chk_sel;
    bit               sel;
    bit               chk_busy;
    logic [CNT_W-1:0] busy;
    int               base [5];
    logic [4:0]       dlt;
  } exp_t;

  exp_t sb[$];

  task automatic push(input string tag, input bit err, input bit chk_sel, input bit sel,
                      input bit chk_busy, input int busy, input logic [4:0] dlt);
    exp_t e;
    e.tag      = tag;
    e.err      = err;
    e.chk_sel  = chk_sel;
    e.sel      = sel;
    e.chk_busy = chk_busy;
    e.busy     = CNT_W'(busy);
    e.base     = cnt;
    e.dlt      = dlt;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] c);
    @(negedge clk);
    arm_to_fpga_cmd       = c;
    arm_to_fpga_cmd_valid = 1'b1;
    @(negedge clk);
    arm_to_fpga_cmd_valid = 1'b0;
    arm_to_fpga_cmd       = 32'h0;
  endtask

  task automatic wait_done(input int budget, output int waited);
    exp_t e;
    waited = 0;
    while (!fpga_to_arm_done && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (!fpga_to_arm_done) begin
      check("done_timeout", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_err"}, cmd_err, e.err);
      if (e.chk_sel)  check({e.tag, "_res_sel"}, res_sel, e.sel);
      if (e.chk_busy) check({e.tag, "_busy"}, busy_cycles, e.busy);
      for (int i = 0; i < 5; i++)
        check($sformatf("%s_strobe%0d", e.tag, i), cnt[i] - e.base[i], e.dlt[i]);
    end
  endtask

  task automatic ack(input int hold);
    repeat (hold) @(negedge clk);
    check("done_held", fpga_to_arm_done, 1'b1);
    fpga_to_arm_done_read = 1'b1;
    @(negedge clk);
    fpga_to_arm_done_read = 1'b0;
    check("idle_after_ack", {fpga_to_arm_done, leds[1:0]}, 3'b000);
  endtask

  task automatic do_read(input string tag, input logic [31:0] c, input int idx,
                         input bit pre_valid, input int delay);
    int w;
    push(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0, 5'(1 << idx));
    arm_to_fpga_data_valid = pre_valid;
    issue(c);
    check({tag, "_ready"}, arm_to_fpga_data_ready, 1'b1);
    if (!pre_valid) begin
      repeat (delay) @(negedge clk);
      arm_to_fpga_data_valid = 1'b1;
    end
    @(negedge clk);
    arm_to_fpga_data_valid = 1'b0;
    wait_done(4, w);
    check({tag, "_latency"}, w, 0);
  endtask

  task automatic run_core(input bit is_exp, input int lat, input int spur);
    int t = 0;
    while (!(is_exp ? exp_start : mont_start) && t < 5) begin
      @(negedge clk);
      t++;
    end
    if (!(is_exp ? exp_start : mont_start)) begin
      check("start_seen", 64'd0, 64'd1);
      return;
    end
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      mont_done = (i == spur) || (!is_exp && i == lat);
      exp_done  = is_exp && (i == lat);
    end
    @(negedge clk);
    mont_done = 1'b0;
    exp_done  = 1'b0;
  endtask

  task automatic do_compute(input string tag, input bit is_exp, input int lat, input int spur);
    int w;
    push(tag, 1'b0, 1'b1, is_exp, 1'b1, lat, is_exp ? 5'b10000 : 5'b01000);
    issue(is_exp ? 32'd0 : 32'd1);
    run_core(is_exp, lat, spur);
    wait_done(4, w);
    check({tag, "_res_valid"}, leds[2], 1'b1);
    ack(0);
  endtask

  task automatic do_write(input string tag, input bit ok, input bit sel, input int ready_delay);
    int w;
    push(tag, !ok, ok, sel, 1'b0, 0, 5'b00000);
    issue(32'd5);
    check({tag, "_data_valid"}, fpga_to_arm_data_valid, ok);
    if (ok) begin
      check({tag, "_tx_sel"}, res_sel, sel);
      repeat (ready_delay) @(negedge clk);
      check({tag, "_valid_held"}, fpga_to_arm_data_valid, 1'b1);
      fpga_to_arm_data_ready = 1'b1;
      @(negedge clk);
      fpga_to_arm_data_ready = 1'b0;
      check({tag, "_valid_drop"}, fpga_to_arm_data_valid, 1'b0);
    end
    wait_done(4, w);
    check({tag, "_latency"}, w, 0);
    ack(0);
  endtask

  initial begin
    int w;
    int base_mont;
    reset                  = 1'b1;
    arm_to_fpga_cmd        = 32'h0;
    arm_to_fpga_cmd_valid  = 1'b0;
    fpga_to_arm_done_read  = 1'b0;
    arm_to_fpga_data_valid = 1'b0;
    fpga_to_arm_data_ready = 1'b0;
    mont_done              = 1'b0;
    exp_done               = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
                         ld_mod, ld_rsq, ld_exp, mont_start, exp_start, res_sel, cmd_err, leds}, 14'd0);
    check("reset_busy", busy_cycles, 0);
    reset = 1'b0;

    // WRITE with no result yet.
    do_write("write_nores", 1'b0, 1'b0, 0);

    // Operand loads.
    do_read("rd_rsq", 32'd3, 1, 1'b0, 2);
    ack(0);
    do_read("rd_mod", 32'd2, 0, 1'b1, 0);
    ack(0);
    do_read("rd_exp", 32'd4, 2, 1'b0, 0);
    ack(0);

    // Montgomery compute then a WRITE with ready withheld.
    do_compute("mont", 1'b0, 40, 0);
    do_write("write_mont", 1'b1, 1'b0, 3);

    // Exponentiation with a spurious mont_done, then two WRITEs.
    do_compute("exp", 1'b1, 1000, 10);
    do_write("write_exp1", 1'b1, 1'b1, 0);
    do_write("write_exp2", 1'b1, 1'b1, 2);

    // Illegal commands.
    push("ill7", 1'b1, 1'b0, 1'b0, 1'b0, 0, 5'b00000);
    issue(32'd7);
    wait_done(4, w);
    ack(0);
    push("ill8", 1'b1, 1'b0, 1'b0, 1'b0, 0, 5'b00000);
    issue(32'h8);
    wait_done(4, w);
    ack(0);

    // Command issued during DONE is dropped; the next one proceeds.
    do_read("rd_drop", 32'd3, 1, 1'b0, 1);
    base_mont = cnt[3];
    @(negedge clk);
    arm_to_fpga_cmd       = 32'd1;
    arm_to_fpga_cmd_valid = 1'b1;
    @(negedge clk);
    arm_to_fpga_cmd_valid = 1'b0;
    arm_to_fpga_cmd       = 32'h0;
    ack(3);
    repeat (3) @(negedge clk);
    check("drop_no_start", cnt[3] - base_mont, 0);
    check("drop_idle", leds[1:0], 2'b00);
    do_read("rd_after_drop", 32'd2, 0, 1'b0, 1);
    ack(0);

    // Reset during BUSY of COMPUTE_EXP, then WRITE must report an error.
    issue(32'd0);
    repeat (20) @(negedge clk);
    check("pre_reset_busy", leds[1:0], 2'b11);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outs", {fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
                            ld_mod, ld_rsq, ld_exp, mont_start, exp_start, res_sel, cmd_err, leds}, 14'd0);
    check("midreset_busy", busy_cycles, 0);
    reset = 1'b0;
    do_write("write_after_reset", 1'b0, 1'b0, 0);

    check("ld_without_ready", ld_unready, 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
